sipo_deser: RTL

//   Serial-to-parallel deserializer that consumes the 1-bit stream produced by the

---
 rtl/sipo_deser_if.sv | 37 +++
 rtl/sipo_deser.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sipo_deser_if.sv
// ---------------------------------------------------------------------------
// sipo_deser_if
//   Bundles the serial input side and the parallel valid/ready output side of
//   the SIPO deserializer. The master modport is the environment, which drives
//   the bit stream and consumes words. The slave modport is the deserializer.
//
//   sin         serial data bit, sampled when shift=1
//   shift       bit strobe
//   clear       synchronous abort of the partial word; also clears overrun
//   dout        assembled word
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout
//   busy        a partial word is in progress
//   overrun     sticky; a completed word was dropped
// ---------------------------------------------------------------------------
interface sipo_deser_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             shift;
    logic             clear;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output sin, shift, clear, dout_ready,
        input  dout, dout_valid, busy, overrun
    );

    modport slave (
        input  sin, shift, clear, dout_ready,
        output dout, dout_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deser.sv
// ---------------------------------------------------------------------------
// sipo_deser
//   Serial-to-parallel deserializer. Captures one bit per clock edge with
//   shift=1 and assembles WIDTH-bit words. A finished word goes into a
//   one-deep output register with a valid/ready handshake. When a word
//   finishes while the output register is still full and not being drained,
//   that word is dropped and the sticky overrun flag is set.
//
//   Parameters
//     WIDTH      bits per word (2..32)
//     MSB_FIRST  1: the first received bit ends up in dout[WIDTH-1]
//                0: the first received bit ends up in dout[0]
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous reset, active-high
//     bus     sipo_deser_if slave modport (sin, shift, clear, dout,
//             dout_valid, dout_ready, busy, overrun)
// ---------------------------------------------------------------------------
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    sipo_deser_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             overrun_q;
    logic             busy_q;

    logic [WIDTH-1:0] sr_d;
    logic [CNT_W-1:0] cnt_d;
    logic             complete_d;
    logic             accept_d;

    // Shift register with the incoming bit already included. On the
    // completing edge this is exactly the finished word, which is what lets
    // dout load with no extra cycle of latency.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_d = {sr_q[WIDTH-2:0], bus.sin};
        end else begin : g_lsb_first
            assign sr_d = {bus.sin, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // A completing edge is the WIDTH-th captured bit, unless clear
    // overrides it. The word is accepted into dout only if the output
    // register is empty or is being drained on the same edge.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        complete_d = bus.shift & ~bus.clear & (cnt_q == LAST_CNT);
        accept_d   = complete_d & (~valid_q | bus.dout_ready);
    end

    // Collection FSM, output register and overrun flag. clear only touches
    // the partial word and overrun; the output handshake keeps running
    // independently so a pending word is never lost to a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (bus.clear) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                sr_q    <= '0;
                busy_q  <= 1'b0;
            end else if (bus.shift) begin
                sr_q <= sr_d;
                case (state_q)
                    IDLE: begin
                        state_q <= COLLECT;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                    end
                    COLLECT: begin
                        if (cnt_q == LAST_CNT) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_d;
                            busy_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            if (accept_d) begin
                dout_q  <= sr_d;
                valid_q <= 1'b1;
            end else if (valid_q & bus.dout_ready) begin
                valid_q <= 1'b0;
            end

            if (bus.clear) begin
                overrun_q <= 1'b0;
            end else if (complete_d & ~accept_d) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule
